// File: rtl/dual_seq_detector_checker.sv
// Two independent serial pattern detectors with a saturating coincidence counter.
// Optional macro RESULT_WRAP_EN: the coincidence counter wraps modulo 16 instead of saturating.
module dual_seq_detector_checker #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN1 = 4'b1011,
  parameter logic [PAT_LEN-1:0] PATTERN2 = 4'b1101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seq1,
  input  logic       seq2,
  output logic [1:0] mode,
  output logic [3:0] result
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [1:0] seq_vec;
  logic [1:0] hit;
  logic [1:0] mode_reg;
  logic [3:0] result_reg;
  logic [3:0] result_next;

  assign seq_vec = {seq2, seq1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic [PAT_LEN-1:0] PAT = (gi == 0) ? PATTERN1 : PATTERN2;

      logic [PAT_LEN-2:0] hist_reg;
      logic [PAT_LEN-2:0] hist_next;
      logic [FILL_W-1:0]  fill_reg;
      logic [FILL_W-1:0]  fill_next;
      logic [PAT_LEN-1:0] win;

      // The window includes the bit being sampled this edge, so a hit is
      // decided in the same cycle the final pattern bit arrives.
      assign win       = {hist_reg, seq_vec[gi]};
      assign hist_next = win[PAT_LEN-2:0];
      assign fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 1'b1;
      assign hit[gi]   = (win == PAT) && (fill_reg == FILL_MAX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_reg <= '0;
          fill_reg <= '0;
        end else begin
          hist_reg <= hist_next;
          fill_reg <= fill_next;
        end
      end
    end
  endgenerate

  always_comb begin
    result_next = result_reg;
    if (&hit) begin
`ifdef RESULT_WRAP_EN
      result_next = result_reg + 4'd1;
`else
      if (result_reg != 4'hF) begin
        result_next = result_reg + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg   <= 2'b00;
      result_reg <= 4'd0;
    end else begin
      mode_reg   <= hit;
      result_reg <= result_next;
    end
  end

  assign mode   = mode_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_dual_seq_detector_checker.sv
// Scoreboard bench for dual_seq_detector_checker: a bit-queue model predicts mode/result per edge.
module tb_dual_seq_detector_checker;

  localparam int         PAT_LEN = 4;
  localparam logic [3:0] P1      = 4'b1011;
  localparam logic [3:0] P2      = 4'b1101;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] result;
  } exp_t;

  logic       clk_tb = 1'b0;
  logic       rst_n  = 1'b0;
  logic       seq1   = 1'b0;
  logic       seq2   = 1'b0;
  logic [1:0] mode;
  logic [3:0] result;

  int   vectors_applied = 0;
  int   miscompares     = 0;
  bit   q1[$];
  bit   q2[$];
  int   m_res = 0;
  exp_t sb[$];

  dual_seq_detector_checker #(
    .PAT_LEN (PAT_LEN),
    .PATTERN1(P1),
    .PATTERN2(P2)
  ) u_dut (
    .clk   (clk_tb),
    .rst_n (rst_n),
    .seq1  (seq1),
    .seq2  (seq2),
    .mode  (mode),
    .result(result)
  );

  always #5 clk_tb = ~clk_tb;

  // Drive one bit per channel, predict the outcome, then compare after the edge.
  task automatic step(input logic b1, input logic b2, output logic [1:0] seen);
    exp_t       e;
    logic [3:0] w1;
    logic [3:0] w2;
    logic       h1;
    logic       h2;
    seq1 = b1;
    seq2 = b2;
    q1.push_back(b1);
    q2.push_back(b2);
    if (q1.size() > PAT_LEN) void'(q1.pop_front());
    if (q2.size() > PAT_LEN) void'(q2.pop_front());
    h1 = 1'b0;
    h2 = 1'b0;
    w1 = '0;
    w2 = '0;
    if (q1.size() == PAT_LEN) begin
      for (int k = 0; k < PAT_LEN; k++) w1 = {w1[2:0], q1[k]};
      h1 = (w1 == P1);
    end
    if (q2.size() == PAT_LEN) begin
      for (int k = 0; k < PAT_LEN; k++) w2 = {w2[2:0], q2[k]};
      h2 = (w2 == P2);
    end
    if (h1 && h2) begin
`ifdef RESULT_WRAP_EN
      m_res = (m_res + 1) % 16;
`else
      if (m_res < 15) m_res = m_res + 1;
`endif
    end
    e.mode   = {h2, h1};
    e.result = 4'(m_res);
    sb.push_back(e);
    @(posedge clk_tb);
    #1;
    e    = sb.pop_front();
    seen = mode;
    vectors_applied++;
    if (mode !== e.mode) begin
      miscompares++;
      $display("FAIL sb_mode t=%0t: got %b expected %b", $time, mode, e.mode);
    end
    vectors_applied++;
    if (result !== e.result) begin
      miscompares++;
      $display("FAIL sb_result t=%0t: got %0d expected %0d", $time, result, e.result);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    seq1  = 1'b0;
    seq2  = 1'b0;
    #1;
    vectors_applied++;
    if (mode !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_mode_in_reset: got %b expected 00", tag, mode);
    end
    vectors_applied++;
    if (result !== 4'd0) begin
      miscompares++;
      $display("FAIL %s_result_in_reset: got %0d expected 0", tag, result);
    end
    q1.delete();
    q2.delete();
    sb.delete();
    m_res = 0;
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset");
    $display("test_reset done: mode=%b result=%0d", mode, result);
  endtask

  task automatic test_single();
    logic [3:0] bits;
    logic [4:0] mask;
    logic [1:0] seen;
    bits = 4'b1011;
    mask = '0;
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? bits[3-i] : 1'b0, 1'b0, seen);
      mask[i] = (seen == 2'b01);
    end
    vectors_applied++;
    if (mask !== 5'b01000) begin
      miscompares++;
      $display("FAIL single_pulse: got mask %b expected 01000", mask);
    end
    $display("test_single: pulse mask %b result=%0d", mask, result);
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [8:0] mask;
    logic [1:0] seen;
    bits = 7'b1011011;
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      step((i < 7) ? bits[6-i] : 1'b0, 1'b0, seen);
      mask[i] = seen[0];
    end
    vectors_applied++;
    if (mask !== 9'b001001000) begin
      miscompares++;
      $display("FAIL overlap_pulses: got mask %b expected 001001000", mask);
    end
    $display("test_overlap: pulse mask %b", mask);
  endtask

  task automatic test_coincidence();
    logic [1:0] seen;
    for (int i = 0; i < 4; i++) step(P1[3-i], P2[3-i], seen);
    vectors_applied++;
    if (seen !== 2'b11 || result !== 4'd1) begin
      miscompares++;
      $display("FAIL coincidence: got mode %b result %0d expected mode 11 result 1", seen, result);
    end
    step(1'b0, 1'b0, seen);
    vectors_applied++;
    if (seen !== 2'b00) begin
      miscompares++;
      $display("FAIL coincidence_one_cycle: got mode %b expected 00", seen);
    end
    $display("test_coincidence: result=%0d", result);
  endtask

  task automatic test_reset_mid_stream();
    logic [1:0] seen;
    step(1'b1, 1'b0, seen);
    step(1'b0, 1'b0, seen);
    step(1'b1, 1'b0, seen);
    do_reset("midreset");
    step(1'b1, 1'b0, seen);
    vectors_applied++;
    if (seen !== 2'b00) begin
      miscompares++;
      $display("FAIL warmup_after_reset: got mode %b expected 00", seen);
    end
    $display("test_reset_mid_stream: mode after final bit %b", seen);
  endtask

  task automatic test_saturation();
    logic [1:0] seen;
    logic [3:0] want;
    do_reset("sat");
    for (int h = 0; h < 17; h++) begin
      for (int i = 0; i < 4; i++) step(P1[3-i], P2[3-i], seen);
      $display("test_saturation: hit %0d result=%0d", h + 1, result);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, seen);
`ifdef RESULT_WRAP_EN
    want = 4'd1;
`else
    want = 4'd15;
`endif
    vectors_applied++;
    if (result !== want) begin
      miscompares++;
      $display("FAIL saturation_final: got %0d expected %0d", result, want);
    end
  endtask

  task automatic test_long_stream();
    logic [31:0] s1;
    logic [31:0] s2;
    logic [35:0] mask;
    logic [35:0] want;
    logic [1:0]  seen;
    do_reset("long");
    s1   = 32'h8BF8BDB1;
    s2   = 32'hBBF8AEB1;
    mask = '0;
    want = '0;
    want[7]  = 1'b1;
    want[19] = 1'b1;
    want[24] = 1'b1;
    want[27] = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step((i < 32) ? s1[31-i] : 1'b0, (i < 32) ? s2[31-i] : 1'b0, seen);
      mask[i] = seen[0];
    end
    vectors_applied++;
    if (mask !== want) begin
      miscompares++;
      $display("FAIL long_seq1_pulses: got %h expected %h", mask, want);
    end
    $display("test_long_stream: seq1 pulse mask %h result=%0d", mask, result);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_coincidence();
    test_reset_mid_stream();
    test_saturation();
    test_long_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
